display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for the 8-digit 7-segment display. It holds a tear-free snapshot of the 32-bit address/data word and steps a 3-bit digit index through all eight digits. It drives the 3-bit nibble-select of the downstream 8-to-1 nibble mux and the active-low digit anodes, with a guard interval at each digit change to suppress ghosting.

## Interface
Parameters:
- TICK_DIV, 100000 — clock cycles per digit dwell (1 kHz per digit at 100 MHz); must be > GUARD + 1
- GUARD, 16 — cycles at the start of each dwell with all anodes off

Ports:
- clk  input  1  system clock; one clock domain
- reset_n  input  1  reset, asynchronous assert, active-low
- data_in  input  32  word to display (nibble k shown on digit k)
- load  input  1  capture request for data_in, single-cycle qualifier
- digit_en  input  8  per-digit enable mask, bit k enables digit k
- blank  input  1  global blank; forces all anodes off
- data_out  output  32  snapshot word feeding the nibble mux data input
- select  output  3  digit index feeding the nibble mux select
- anode  output  8  one-hot active-low digit drive; bit k low lights digit k
- frame_done  output  1  one-cycle pulse at the end of digit 7's dwell

## Operation
- Prescaler: tick_cnt counts 0..TICK_DIV-1 and wraps. tick is asserted when tick_cnt == TICK_DIV-1.
- Digit counter: on tick, select increments mod 8 (7 -> 0). select is a registered output.
- Two-state FSM per dwell:
  - GUARD: entered on tick and out of reset. anode = 8'hFF. Lasts GUARD cycles.
  - DRIVE: anode[select] = 0 if digit_en[select] && !blank; all other bits 1. Lasts until the next tick.
- Load path:
  - load captures data_in into a pending register and sets pend_valid.
  - A later load overwrites pending (last value wins).
- Frame boundary: tick while select == 7.
  - frame_done pulses for that cycle.
  - If load is high on that cycle, data_out <= data_in and pend_valid clears.
  - Otherwise, if pend_valid, data_out <= pending and pend_valid clears.
  - Otherwise data_out holds.
- data_out never changes mid-frame.
- blank and digit_en are sampled combinationally into the anode register. A change takes effect on the next clock, without waiting for a dwell boundary.

## Timing
- Reset values: tick_cnt 0, select 0, FSM GUARD, anode 8'hFF, frame_done 0, data_out 0, pending 0, pend_valid 0.
- Reset deassertion: first dwell starts in GUARD with its guard count at 0.
- Reset asserted mid-operation: all state returns to reset values immediately. No pending word survives.
- Dwell length is exactly TICK_DIV cycles. A full frame is 8*TICK_DIV cycles.
- Within a dwell, GUARD occupies cycles 0..GUARD-1 after the select change; anode goes low at cycle GUARD.
- select and data_out change on the same edge at a frame boundary. The mux output for digit 0 is therefore valid during GUARD.
- frame_done is high for exactly one cycle per frame, coincident with the select 7 -> 0 update edge.
- Load latency to display: at most 8*TICK_DIV cycles. Zero extra frames if load coincides with the boundary.

## Structure
- Shared package disp_pkg: NUM_DIGITS = 8, SEL_W = 3, ANODE_OFF = 8'hFF, and the FSM state enum {S_GUARD, S_DRIVE}.
- One sub-module, scan_tick_gen: parameterised prescaler producing the tick pulse, with the same clk/reset_n.
- Top level contains the digit counter, FSM, anode decode and load/snapshot registers.

## Test plan
All scenarios use TICK_DIV=8, GUARD=2.
- Reset then free-run:
  - select steps 0..7 every 8 cycles.
  - anode reads FF for 2 cycles, then FE for 6 cycles, then FF, FD, and so on.
  - frame_done pulses once every 64 cycles.
- load with data_in=32'h1234_5678 mid-frame:
  - data_out stays 0 until the frame boundary, then becomes 1234_5678 on the same edge as select 7 -> 0.
- Two loads in one frame (AAAA_AAAA, then 5555_5555), plus a load of 0F0F_0F0F coinciding with the boundary tick:
  - data_out = 5555_5555 after the first boundary.
  - The next frame shows 0F0F_0F0F with no extra frame of delay.
- Masking:
  - digit_en = 8'b1111_0000 lights only digits 4..7.
  - blank asserted in digit 5's DRIVE forces anode = FF on the next cycle.
  - select keeps advancing.
- reset_n pulled low for 1 cycle mid-DRIVE with pend_valid set:
  - All outputs return to reset values asynchronously.
  - The pending word is discarded; data_out = 0 after the next frame.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants, FSM state type and anode decode for the display scan controller
package disp_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam int         SEL_W      = 3;
    localparam logic [7:0] ANODE_OFF  = 8'hFF;

    typedef enum logic {S_GUARD, S_DRIVE} scan_state_t;

    // Active-low one-hot drive for the selected digit, or all off.
    function automatic logic [NUM_DIGITS-1:0] anode_decode(input logic [SEL_W-1:0] sel,
                                                           input logic             lit);
        return lit ? ~(8'd1 << sel) : ANODE_OFF;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - prescaler emitting one tick per TICK_DIV clocks
module scan_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] tick_cnt;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 8-digit 7-segment scan controller with guard interval and tear-free snapshot
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int GUARD    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           data_in,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic                  blank,
    output logic [31:0]           data_out,
    output logic [SEL_W-1:0]      select,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  frame_done
);

    localparam int GW = $clog2(GUARD) + 1;

    logic              tick;
    logic              boundary;
    scan_state_t       state, state_next;
    logic [GW-1:0]     gcnt, gcnt_next;
    logic [SEL_W-1:0]  sel_next;
    logic              lit_next;
    logic [31:0]       pending;
    logic              pend_valid;

    scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign boundary   = tick && (select == 3'd7);
    assign frame_done = boundary;

    always_comb begin
        sel_next   = select;
        state_next = state;
        gcnt_next  = gcnt;
        if (tick) begin
            sel_next   = select + 3'd1;
            state_next = S_GUARD;
            gcnt_next  = '0;
        end else if (state == S_GUARD) begin
            if (gcnt == GW'(GUARD - 1)) begin
                state_next = S_DRIVE;
            end else begin
                gcnt_next = gcnt + 1'b1;
            end
        end
    end

    // The anode register is loaded from next-cycle state so it lines up with select and the FSM.
    assign lit_next = (state_next == S_DRIVE) && digit_en[sel_next] && !blank;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            select <= '0;
            state  <= S_GUARD;
            gcnt   <= '0;
            anode  <= ANODE_OFF;
        end else begin
            select <= sel_next;
            state  <= state_next;
            gcnt   <= gcnt_next;
            anode  <= anode_decode(sel_next, lit_next);
        end
    end

    // data_out only moves at the frame boundary; a load on that very cycle bypasses pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                data_out <= data_in;
            end else if (pend_valid) begin
                data_out <= pending;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pending    <= data_in;
            pend_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl with TICK_DIV=8, GUARD=2
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        load = 1'b0;
    logic [7:0]  digit_en = 8'hFF;
    logic        blank = 1'b0;
    logic [31:0] data_out;
    logic [2:0]  select;
    logic [7:0]  anode;
    logic        frame_done;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    display_scan_ctrl #(.TICK_DIV(8), .GUARD(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .load       (load),
        .digit_en   (digit_en),
        .blank      (blank),
        .data_out   (data_out),
        .select     (select),
        .anode      (anode),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [2:0] sel;
        logic [7:0] an;
        logic       fd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic run_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        load    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic pulse_load(input logic [31:0] d);
        data_in = d;
        load    = 1'b1;
        run_to(cyc + 1);
        load    = 1'b0;
    endtask

    int fd_count;

    initial begin
        vecs[0] = '{0,  3'd0, 8'hFF, 1'b0};
        vecs[1] = '{1,  3'd0, 8'hFF, 1'b0};
        vecs[2] = '{2,  3'd0, 8'hFE, 1'b0};
        vecs[3] = '{7,  3'd0, 8'hFE, 1'b0};
        vecs[4] = '{8,  3'd1, 8'hFF, 1'b0};
        vecs[5] = '{10, 3'd1, 8'hFD, 1'b0};
        vecs[6] = '{62, 3'd7, 8'h7F, 1'b0};
        vecs[7] = '{63, 3'd7, 8'h7F, 1'b1};
        vecs[8] = '{64, 3'd0, 8'hFF, 1'b0};
        vecs[9] = '{66, 3'd0, 8'hFE, 1'b0};

        // Reset values while held in reset
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_select", 32'(select), 32'd0);
        check("rst_anode", 32'(anode), 32'hFF);
        check("rst_data_out", data_out, 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // Free-run scan table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_to(vecs[i].k);
            check($sformatf("scan_sel_k%0d", vecs[i].k), 32'(select), 32'(vecs[i].sel));
            check($sformatf("scan_anode_k%0d", vecs[i].k), 32'(anode), 32'(vecs[i].an));
            check($sformatf("scan_fd_k%0d", vecs[i].k), 32'(frame_done), 32'(vecs[i].fd));
        end

        // frame_done exactly once per 64 cycles
        do_reset();
        fd_count = 0;
        for (int i = 0; i < 128; i++) begin
            run_to(cyc + 1);
            if (frame_done) fd_count++;
        end
        check("fd_count_128", 32'(fd_count), 32'd2);

        // Mid-frame load, two loads in a frame, then load coinciding with boundary
        do_reset();
        run_to(20);
        pulse_load(32'h1234_5678);
        run_to(63);
        check("load_hold_pre", data_out, 32'd0);
        check("load_hold_sel", 32'(select), 32'd7);
        run_to(64);
        check("load_shown", data_out, 32'h1234_5678);
        check("load_shown_sel", 32'(select), 32'd0);
        run_to(70);
        pulse_load(32'hAAAA_AAAA);
        run_to(90);
        pulse_load(32'h5555_5555);
        run_to(127);
        check("two_load_hold", data_out, 32'h1234_5678);
        run_to(128);
        check("two_load_last", data_out, 32'h5555_5555);
        run_to(191);
        check("bnd_load_pre", data_out, 32'h5555_5555);
        pulse_load(32'h0F0F_0F0F);
        check("bnd_load_now", data_out, 32'h0F0F_0F0F);
        check("bnd_load_sel", 32'(select), 32'd0);
        run_to(256);
        check("bnd_no_stale", data_out, 32'h0F0F_0F0F);

        // Masking and blank
        digit_en = 8'hF0;
        do_reset();
        run_to(2);
        check("mask_d0_off", 32'(anode), 32'hFF);
        run_to(34);
        check("mask_d4_on", 32'(anode), 32'hEF);
        run_to(42);
        check("mask_d5_on", 32'(anode), 32'hDF);
        run_to(43);
        blank = 1'b1;
        run_to(44);
        check("blank_anode", 32'(anode), 32'hFF);
        check("blank_sel", 32'(select), 32'd5);
        run_to(48);
        check("blank_sel_adv", 32'(select), 32'd6);
        check("blank_anode_d6", 32'(anode), 32'hFF);
        run_to(50);
        blank = 1'b0;
        run_to(51);
        check("unblank_d6", 32'(anode), 32'hBF);
        digit_en = 8'hFF;

        // Async reset mid-DRIVE with a pending word
        do_reset();
        run_to(10);
        pulse_load(32'hDEAD_BEEF);
        run_to(20);
        check("pre_rst_anode", 32'(anode), 32'hFB);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_sel", 32'(select), 32'd0);
        check("async_rst_anode", 32'(anode), 32'hFF);
        check("async_rst_data", data_out, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        run_to(64);
        check("rst_discard_pend", data_out, 32'd0);
        check("rst_resume_sel", 32'(select), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
